// File: rtl/cell_next_state.sv
// Life (B3/S23) next-state engine: reads a cell plus its 8 neighbours, writes the new state.
// Build option TORUS_WRAP_EN: wrap neighbours around the board edges; otherwise off-board neighbours are dead.
module cell_next_state #(
  parameter int AW = 7,
  parameter int CW = 15
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   addrR,
  input  logic [AW-1:0]   addrC,
  input  logic            in_last,
  output logic            rd_en,
  output logic [2*AW-1:0] rd_addr,
  input  logic            rd_data,
  output logic            wr_en,
  output logic [2*AW-1:0] wr_addr,
  output logic            wr_data,
  output logic            gen_done,
  output logic [CW-1:0]   pop_count
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [AW-1:0]   row_q, col_q;
  logic            last_q;
  logic            smp_vld_q, smp_self_q;
  logic            self_q;
  logic [3:0]      nsum_q;
  logic [CW-1:0]   run_q, pop_q;
  logic            gen_done_q;

  logic            up, dn, lf, rt, off_board, slot_on, next_bit;
  logic [AW-1:0]   nr, nc;

  // Slot k: 0 self, 1 NW, 2 N, 3 NE, 4 W, 5 E, 6 SW, 7 S, 8 SE
  always_comb begin
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    case (k_q)
      4'd1: begin up = 1'b1; lf = 1'b1; end
      4'd2: up = 1'b1;
      4'd3: begin up = 1'b1; rt = 1'b1; end
      4'd4: lf = 1'b1;
      4'd5: rt = 1'b1;
      4'd6: begin dn = 1'b1; lf = 1'b1; end
      4'd7: dn = 1'b1;
      4'd8: begin dn = 1'b1; rt = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    nr = row_q;
    nc = col_q;
    if (up) nr = row_q - AW'(1);
    if (dn) nr = row_q + AW'(1);
    if (lf) nc = col_q - AW'(1);
    if (rt) nc = col_q + AW'(1);
    off_board = (up && row_q == '0) || (dn && &row_q) ||
                (lf && col_q == '0) || (rt && &col_q);
`ifdef TORUS_WRAP_EN
    slot_on = 1'b1;
`else
    slot_on = !off_board;
`endif
  end

  assign next_bit  = (nsum_q == 4'd3) || (self_q && nsum_q == 4'd2);

  assign in_ready  = rst_b && (state_q == IDLE);
  assign rd_en     = (state_q == READ) && slot_on;
  assign rd_addr   = rd_en ? {nr, nc} : '0;
  assign wr_en     = (state_q == WRITE);
  assign wr_addr   = wr_en ? {row_q, col_q} : '0;
  assign wr_data   = wr_en && next_bit;
  assign gen_done  = gen_done_q;
  assign pop_count = pop_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:  if (in_valid) begin state_d = READ; k_d = '0; end
      READ:  if (k_q == 4'd8) state_d = DRAIN;
             else k_d = k_q + 4'd1;
      DRAIN: state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      smp_vld_q  <= 1'b0;
      smp_self_q <= 1'b0;
      self_q     <= 1'b0;
      nsum_q     <= '0;
      run_q      <= '0;
      pop_q      <= '0;
      gen_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      gen_done_q <= 1'b0;
      // Remember which slot was read so its data can be routed one cycle later
      smp_vld_q  <= rd_en;
      smp_self_q <= (state_q == READ) && (k_q == 4'd0);
      if (state_q == IDLE && in_valid) begin
        row_q  <= addrR;
        col_q  <= addrC;
        last_q <= in_last;
        self_q <= 1'b0;
        nsum_q <= '0;
      end
      if (smp_vld_q) begin
        if (smp_self_q) self_q <= rd_data;
        else            nsum_q <= nsum_q + {3'b000, rd_data};
      end
      if (state_q == WRITE) begin
        if (last_q) begin
          pop_q      <= run_q + CW'(next_bit);
          run_q      <= '0;
          gen_done_q <= 1'b1;
        end else begin
          run_q <= run_q + CW'(next_bit);
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_next_state.sv
// Directed-vector scoreboard bench for cell_next_state with a behavioural board RAM.
module tb_cell_next_state;
  localparam int AW = 7;
  localparam int CW = 15;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AW-1:0]   addrR = '0, addrC = '0;
  logic            in_last = 1'b0;
  logic            rd_en;
  logic [2*AW-1:0] rd_addr;
  logic            rd_data = 1'b0;
  logic            wr_en;
  logic [2*AW-1:0] wr_addr;
  logic            wr_data;
  logic            gen_done;
  logic [CW-1:0]   pop_count;

  cell_next_state #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .addrR(addrR), .addrC(addrC), .in_last(in_last),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gen_done(gen_done), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*AW-1:0] addr;
    logic            data;
    int              pulses;
  } exp_t;

  exp_t  wq[$];
  int    gq[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, last_hs = 0, rd_cnt = 0;
  logic  mem [0:(1<<(2*AW))-1];

  // Unread slots return 1 so a design that samples them gets caught
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? mem[rd_addr] : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or flags end of generation
  always @(negedge clk) begin
    if (rst_b) begin
      if (in_valid && in_ready) begin
        last_hs = cyc;
        rd_cnt  = 0;
      end
      if (rd_en) rd_cnt++;
      if (wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("rd_pulses", rd_cnt, e.pulses);
          chk("wr_latency", cyc - last_hs, 11);
          chk("rd_wr_overlap", rd_en, 0);
        end
      end
      if (gen_done) begin
        if (gq.size() == 0) begin
          chk("unexpected_gen_done", 1, 0);
        end else begin
          chk("pop_count", pop_count, gq.pop_front());
          chk("gen_done_latency", cyc - last_hs, 12);
        end
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < (1 << (2*AW)); i++) mem[i] = 1'b0;
  endtask

  task automatic set_cell(input int r, input int c);
    mem[r*(1<<AW) + c] = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  // Drive one cell and push what the DUT must write for it
  task automatic send(input int r, input int c, input logic last, input logic d,
                      input int pulses, input bit push);
    exp_t e;
    if (push) begin
      e.addr = {r[AW-1:0], c[AW-1:0]};
      e.data = d;
      e.pulses = pulses;
      wq.push_back(e);
    end
    @(posedge clk); #1;
    addrR = r[AW-1:0]; addrC = c[AW-1:0]; in_last = last; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || gq.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (wq.size() != 0 || gq.size() != 0) chk("drain_timeout", wq.size() + gq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  int hs_prev;

  initial begin
    clear_board();
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_gen_done", gen_done, 0);
    chk("rst_pop_count", pop_count, 0);

    // Lone live cell dies
    set_cell(5, 5);
    send(5, 5, 0, 0, 9, 1);
    drain();

    // Horizontal blinker: 3-cell generation, two of them live next
    clear_board();
    set_cell(10, 9); set_cell(10, 10); set_cell(10, 11);
    send(9, 10, 0, 1, 9, 1);
    send(10, 9, 0, 0, 9, 1);
    gq.push_back(2);
    send(10, 10, 1, 1, 9, 1);
    drain();
    // Next generation counts from zero
    gq.push_back(1);
    send(11, 10, 1, 1, 9, 1);
    drain();

    // Corners
    clear_board();
    set_cell(127, 127); set_cell(127, 0); set_cell(0, 127);
`ifdef TORUS_WRAP_EN
    send(0, 0, 0, 1, 9, 1);
    send(127, 127, 0, 1, 9, 1);
`else
    send(0, 0, 0, 0, 4, 1);
    send(127, 127, 0, 0, 4, 1);
`endif
    drain();

    // in_valid held continuously: one handshake every 12 cycles
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.addr = {7'd64, 7'd64}; e.data = 1'b0; e.pulses = 9;
      wq.push_back(e);
    end
    @(posedge clk); #1;
    addrR = 7'd64; addrC = 7'd64; in_last = 1'b0; in_valid = 1'b1;
    hs_prev = 0;
    for (int h = 0; h < 3; h++) begin
      wait_ready();
      if (h > 0) chk("hs_spacing", cyc - hs_prev, 12);
      hs_prev = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of READ drops the cell
    send(64, 64, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_low", in_ready, 0);
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_pop_count", pop_count, 0);
    chk("post_rst_wr_en", wr_en, 0);
    repeat (20) @(negedge clk);

    // Single-cell generation after reset
`ifdef TORUS_WRAP_EN
    gq.push_back(1);
    send(127, 127, 1, 1, 9, 1);
`else
    gq.push_back(0);
    send(127, 127, 1, 0, 4, 1);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
